// File: rtl/mult_div_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: operation codes,
// FSM states and small operation-decode helpers.
package mult_div_unit_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } mdop_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2
  } mdstate_t;

  // Codes 6-7 are neither arithmetic nor moves, so they fall through as no-ops.
  function automatic logic op_arith(input mdop_t op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic op_signed(input mdop_t op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic op_div(input mdop_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
interface mult_div_unit_if
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
);

  logic             start;
  mdop_t            md_op;
  logic [WIDTH-1:0] port_a;
  logic [WIDTH-1:0] port_b;
  logic             flush;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport md (
    input  start, md_op, port_a, port_b, flush,
    output busy, done, div_by_zero, hi, lo
  );

  modport tb (
    output start, md_op, port_a, port_b, flush,
    input  busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/mult_div_unit_signfix.sv
// Conditional two's-complement negate; used for operand magnitudes on entry
// and for sign correction of results in FIXUP.
module mult_div_unit_signfix #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res_c
);

  assign res_c = neg ? ((~val) + W'(1)) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on
// magnitudes, one bit per cycle, with sign correction in a final FIXUP cycle.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic       CLK,
  input logic       nRST,
  mult_div_unit_if.md bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  mdstate_t         state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             is_div, rsign, remsign, dbz;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] qr, m;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q, dbz_q, busy_q;

  mdop_t            op_c;
  logic             a_neg_c, b_neg_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic             launch_c, mt_wr_c, fixup_wr_c;

  assign op_c    = bus.md_op;
  assign a_neg_c = op_signed(op_c) & bus.port_a[WIDTH-1];
  assign b_neg_c = op_signed(op_c) & bus.port_b[WIDTH-1];

  mult_div_unit_signfix #(.W(WIDTH)) u_abs_a (.val(bus.port_a), .neg(a_neg_c), .res_c(a_mag_c));
  mult_div_unit_signfix #(.W(WIDTH)) u_abs_b (.val(bus.port_b), .neg(b_neg_c), .res_c(b_mag_c));

  // One iteration of each algorithm; acc:qr is the shared double-width working pair.
  logic [WIDTH-1:0] mul_addend_c;
  logic [WIDTH:0]   mul_sum_c, mul_acc_c;
  logic [WIDTH-1:0] mul_qr_c;
  logic [WIDTH:0]   div_shift_c, div_acc_c;
  logic [WIDTH-1:0] div_qr_c;
  logic             div_ge_c;

  always_comb begin
    mul_addend_c = qr[0] ? m : '0;
    mul_sum_c    = acc + {1'b0, mul_addend_c};
    mul_acc_c    = {1'b0, mul_sum_c[WIDTH:1]};
    mul_qr_c     = {mul_sum_c[0], qr[WIDTH-1:1]};
    div_shift_c  = {acc[WIDTH-1:0], qr[WIDTH-1]};
    div_ge_c     = (div_shift_c >= {1'b0, m});
    div_acc_c    = div_ge_c ? (div_shift_c - {1'b0, m}) : div_shift_c;
    div_qr_c     = {qr[WIDTH-2:0], div_ge_c};
  end

  // Sign correction of the finished magnitudes.
  logic [2*WIDTH-1:0] prod_fix_c;
  logic [WIDTH-1:0]   quo_fix_c, rem_fix_c;
  logic [WIDTH-1:0]   hi_new_c, lo_new_c;

  mult_div_unit_signfix #(.W(2*WIDTH)) u_fix_prod (
    .val({acc[WIDTH-1:0], qr}), .neg(rsign), .res_c(prod_fix_c));
  mult_div_unit_signfix #(.W(WIDTH)) u_fix_quo (.val(qr), .neg(rsign), .res_c(quo_fix_c));
  mult_div_unit_signfix #(.W(WIDTH)) u_fix_rem (
    .val(acc[WIDTH-1:0]), .neg(remsign), .res_c(rem_fix_c));

  // Divide by zero leaves |dividend| in acc, so the signed remainder fix restores port_a.
  assign hi_new_c = is_div ? rem_fix_c : prod_fix_c[2*WIDTH-1:WIDTH];
  assign lo_new_c = is_div ? (dbz ? '1 : quo_fix_c) : prod_fix_c[WIDTH-1:0];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    launch_c   = 1'b0;
    mt_wr_c    = 1'b0;
    fixup_wr_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.flush) begin
          launch_c = op_arith(op_c);
          mt_wr_c  = (op_c == MD_MTHI) || (op_c == MD_MTLO);
        end
        if (launch_c) state_next = CALC;
      end
      CALC: begin
        if (bus.flush)        state_next = IDLE;
        else if (cnt == '0)   state_next = FIXUP;
      end
      FIXUP: begin
        fixup_wr_c = !bus.flush;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      rsign   <= 1'b0;
      remsign <= 1'b0;
      dbz     <= 1'b0;
      acc     <= '0;
      qr      <= '0;
      m       <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= fixup_wr_c;
      dbz_q  <= fixup_wr_c & is_div & dbz;
      busy_q <= (state_next != IDLE);
      if (launch_c) begin
        cnt     <= CNT_W'(WIDTH - 1);
        is_div  <= op_div(op_c);
        rsign   <= a_neg_c ^ b_neg_c;
        remsign <= a_neg_c;
        dbz     <= op_div(op_c) && (bus.port_b == '0);
        acc     <= '0;
        qr      <= a_mag_c;
        m       <= b_mag_c;
      end else if (state == CALC) begin
        cnt <= cnt - CNT_W'(1);
        acc <= is_div ? div_acc_c : mul_acc_c;
        qr  <= is_div ? div_qr_c  : mul_qr_c;
      end
      if (fixup_wr_c) begin
        hi_q <= hi_new_c;
        lo_q <= lo_new_c;
      end else if (mt_wr_c) begin
        if (op_c == MD_MTHI) hi_q <= bus.port_a;
        else                 lo_q <= bus.port_a;
      end
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-written
// corner sequences and random operations against an arithmetic reference model.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [31:0] model_hi, model_lo;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32)) dut (
    .CLK (clk),
    .nRST(rst_n),
    .bus (bus.md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    mdop_t       op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results straight from the arithmetic definitions.
  function automatic void model(input mdop_t op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] rhi, output logic [31:0] rlo,
                                output logic rdbz);
    logic [63:0] p;
    longint      sp;
    int          sa, sb;
    sa   = $signed(a);
    sb   = $signed(b);
    rdbz = 1'b0;
    rhi  = '0;
    rlo  = '0;
    case (op)
      MD_MULT: begin
        sp  = longint'(sa) * longint'(sb);
        p   = 64'(sp);
        rhi = p[63:32];
        rlo = p[31:0];
      end
      MD_MULTU: begin
        p   = {32'd0, a} * {32'd0, b};
        rhi = p[63:32];
        rlo = p[31:0];
      end
      MD_DIVU: begin
        if (b == 0) begin rlo = '1; rhi = a; rdbz = 1'b1; end
        else begin rlo = a / b; rhi = a % b; end
      end
      MD_DIV: begin
        if (b == 0) begin rlo = '1; rhi = a; rdbz = 1'b1; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin rlo = 32'h8000_0000; rhi = '0; end
        else begin rlo = 32'(sa / sb); rhi = 32'(sa % sb); end
      end
      default: ;
    endcase
  endfunction

  // Launch in cycle 0, expect busy in 1..33 with hi/lo holding, done in 34.
  task automatic run_op(input mdop_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                        input string tag);
    bit ok;
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.port_a = a;
    bus.port_b = b;
    tick();
    bus.start = 1'b0;
    ok = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      if (!(bus.busy === 1'b1 && bus.done === 1'b0 && bus.hi === model_hi && bus.lo === model_lo))
        ok = 1'b0;
      tick();
    end
    check({tag, " busy_window"}, 64'(ok), 64'd1);
    check({tag, " done"}, 64'(bus.done), 64'd1);
    check({tag, " busy_end"}, 64'(bus.busy), 64'd0);
    check({tag, " hi"}, 64'(bus.hi), 64'(ehi));
    check({tag, " lo"}, 64'(bus.lo), 64'(elo));
    check({tag, " dbz"}, 64'(bus.div_by_zero), 64'(edbz));
    model_hi = ehi;
    model_lo = elo;
    tick();
    check({tag, " done_pulse"}, {62'd0, bus.done, bus.div_by_zero}, 64'd0);
  endtask

  initial begin
    logic [31:0] ehi, elo;
    logic        edbz;
    mdop_t       rop;
    logic [31:0] ra, rb;
    bit          ok;

    checks = 0;
    errors = 0;
    model_hi = '0;
    model_lo = '0;

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{MD_DIVU,  32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 1'b0};
    vecs[5] = '{MD_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 1'b0};
    vecs[7] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,        1'b0};
    vecs[8] = '{MD_DIVU,  32'd10,        32'd3,        32'd1,         32'd3,         1'b0};

    bus.start  = 1'b0;
    bus.md_op  = MD_MULT;
    bus.port_a = '0;
    bus.port_b = '0;
    bus.flush  = 1'b0;
    rst_n      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset flags", {61'd0, bus.busy, bus.done, bus.div_by_zero}, 64'd0);

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dbz,
             $sformatf("vec%0d", i));

    // MTHI then MTLO back to back.
    bus.start = 1'b1; bus.md_op = MD_MTHI; bus.port_a = 32'h1234_5678;
    tick();
    check("mthi hi", 64'(bus.hi), 64'h1234_5678);
    check("mthi flags", {62'd0, bus.busy, bus.done}, 64'd0);
    bus.md_op = MD_MTLO; bus.port_a = 32'h9ABC_DEF0;
    tick();
    bus.start = 1'b0;
    check("mtlo lo", 64'(bus.lo), 64'h9ABC_DEF0);
    check("mtlo hi", 64'(bus.hi), 64'h1234_5678);
    check("mtlo flags", {62'd0, bus.busy, bus.done}, 64'd0);
    model_hi = 32'h1234_5678;
    model_lo = 32'h9ABC_DEF0;

    // Undefined op code and flushed MTHI both leave the unit untouched.
    bus.start = 1'b1; bus.md_op = mdop_t'(3'd6); bus.port_a = 32'hDEAD_BEEF;
    tick();
    check("op6 busy", 64'(bus.busy), 64'd0);
    check("op6 hi", {bus.hi, bus.lo}, {model_hi, model_lo});
    bus.md_op = MD_MTHI; bus.flush = 1'b1;
    tick();
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_idle hi", 64'(bus.hi), 64'(model_hi));
    check("flush_idle busy", 64'(bus.busy), 64'd0);

    // MULT with an ignored second start in cycle 5.
    bus.start = 1'b1; bus.md_op = MD_MULT; bus.port_a = 32'hFFFF_FFFD; bus.port_b = 32'd7;
    tick();
    bus.start = 1'b0;
    ok = 1'b1;
    for (int c = 1; c <= 33; c++) begin
      if (c == 5) begin
        bus.start = 1'b1; bus.md_op = MD_DIVU; bus.port_a = 32'd10; bus.port_b = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) ok = 1'b0;
      tick();
    end
    check("ignore busy_window", 64'(ok), 64'd1);
    check("ignore done", 64'(bus.done), 64'd1);
    check("ignore result", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    model_hi = 32'hFFFF_FFFF;
    model_lo = 32'hFFFF_FFEB;
    ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) ok = 1'b0;
    end
    check("ignore not_queued", 64'(ok), 64'd1);

    // Flush a DIV in cycle 10.
    bus.start = 1'b1; bus.md_op = MD_DIV; bus.port_a = 32'd100; bus.port_b = 32'd7;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    check("flush pre busy", 64'(bus.busy), 64'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("flush busy", 64'(bus.busy), 64'd0);
    ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
      tick();
    end
    check("flush no_done", 64'(ok), 64'd1);
    check("flush hilo", {bus.hi, bus.lo}, {model_hi, model_lo});

    // Asynchronous reset between edges while in CALC.
    bus.start = 1'b1; bus.md_op = MD_DIVU; bus.port_a = 32'd1000; bus.port_b = 32'd9;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async hi", 64'(bus.hi), 64'd0);
    check("async lo", 64'(bus.lo), 64'd0);
    check("async busy", 64'(bus.busy), 64'd0);
    model_hi = '0;
    model_lo = '0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset flags", {62'd0, bus.busy, bus.done}, 64'd0);
    run_op(MD_DIVU, 32'd10, 32'd3, 32'd1, 32'd3, 1'b0, "post_reset divu");

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = mdop_t'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
      model(rop, ra, rb, ehi, elo, edbz);
      run_op(rop, ra, rb, ehi, elo, edbz, $sformatf("rand%0d %s %h %h", i, rop.name(), ra, rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
